rr_arbiter: RTL and testbench

Parametrised N-way arbiter that grants one shared resource to one of N_REQ requesters. A grant is held for as long as the holder keeps requesting. It supports round-robin or fixed-priority selection and hands the grant directly to the next requester in the cycle the holder releases, with no idle cycle between owners. It replaces the fixed three-requester arbiter in the shared-resource path.

---
 rtl/rr_arbiter_if.sv | 29 ++
 rtl/rr_arbiter.sv | 126 ++++++++++++
 tb/tb_rr_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the requesters and the shared-resource arbiter.
// The master drives requests; the slave (arbiter) drives the grant side.
interface rr_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic             gnt_valid;
    logic [IDW-1:0]   gnt_id;
    logic             preempt;

    modport master (
        output req,
        input  gnt,
        input  gnt_valid,
        input  gnt_id,
        input  preempt
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_valid,
        output gnt_id,
        output preempt
    );
endinterface

// File: rtl/rr_arbiter.sv
// N-way round-robin / fixed-priority arbiter with grant hold and zero-gap handover.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD owned cycles.
module rr_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MODE     = 0,
    parameter int MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        reset,
    rr_arbiter_if.slave bus
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW  = $clog2(MAX_HOLD + 1);

`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pre_q, pre_d;

    logic [N_REQ-1:0] cand;
    logic [IDW:0]     idx;
    logic [IDW-1:0]   win;
    logic             found;
    logic             hold;
    logic             timeout;
    logic             take;

    // Candidate set excludes the current holder so a release or
    // timeout always hands over to someone else.
    always_comb begin
        cand = bus.req;
        if (state_q == OWNED) cand[id_q] = 1'b0;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (MODE == 0) idx = {1'b0, ptr_q} + (IDW+1)'(i);
            else           idx = (IDW+1)'(i);
            if (idx >= (IDW+1)'(N_REQ)) idx = idx - (IDW+1)'(N_REQ);
            if (!found && cand[idx[IDW-1:0]]) begin
                found = 1'b1;
                win   = idx[IDW-1:0];
            end
        end
    end

    assign hold    = bus.req[id_q];
    assign timeout = TO_EN && (state_q == OWNED) && hold &&
                     (cnt_q == CW'(MAX_HOLD - 1)) && (|cand);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        pre_d   = 1'b0;
        take    = 1'b0;
        unique case (state_q)
            IDLE: begin
                take = found;
            end
            OWNED: begin
                if (!hold || timeout) begin
                    take  = found;
                    pre_d = timeout;
                    if (!found) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        id_d    = '0;
                        cnt_d   = '0;
                    end
                end else if (cnt_q != CW'(MAX_HOLD)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
        if (take) begin
            state_d    = OWNED;
            gnt_d      = '0;
            gnt_d[win] = 1'b1;
            id_d       = win;
            cnt_d      = '0;
            if (MODE == 0) begin
                ptr_d = (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = |gnt_q;
    assign bus.gnt_id    = id_q;
    assign bus.preempt   = TO_EN & pre_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: round-robin and fixed-priority instances side by side,
// checked every cycle against a queue-free ownership model.
module tb_rr_arbiter;
    localparam int N  = 4;
    localparam int MH = 16;

`ifdef ARB_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req   = '0;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    rr_arbiter_if #(.N_REQ(N)) bus0 ();
    rr_arbiter_if #(.N_REQ(N)) bus1 ();

    assign bus0.req = req;
    assign bus1.req = req;

    rr_arbiter #(.N_REQ(N), .MODE(0), .MAX_HOLD(MH)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    rr_arbiter #(.N_REQ(N), .MODE(1), .MAX_HOLD(MH)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    always #5 clk = ~clk;

    // Model: owner index (-1 idle), RR start point, cycles owned so far.
    int owner[2] = '{-1, -1};
    int ptr[2]   = '{0, 0};
    int held[2]  = '{0, 0};
    bit pre[2]   = '{1'b0, 1'b0};

    function automatic int pick(input int m, input logic [N-1:0] r,
                                input int start);
        int j;
        for (int k = 0; k < N; k++) begin
            j = (m == 0) ? (start + k) % N : k;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            logic [N-1:0] others;
            int w;
            if (reset) begin
                owner[m] = -1;
                ptr[m]   = 0;
                held[m]  = 0;
                pre[m]   = 1'b0;
            end else begin
                pre[m] = 1'b0;
                others = req;
                if (owner[m] >= 0) others[owner[m]] = 1'b0;
                if (owner[m] < 0 || !req[owner[m]] ||
                    (TO && held[m] == MH && others != 0)) begin
                    w = pick(m, others, ptr[m]);
                    pre[m] = (owner[m] >= 0) && req[owner[m]];
                    if (w >= 0) begin
                        owner[m] = w;
                        ptr[m]   = (w + 1) % N;
                        held[m]  = 1;
                    end else begin
                        owner[m] = -1;
                        held[m]  = 0;
                    end
                end else if (held[m] <= MH) begin
                    held[m]++;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input int m, input logic [N-1:0] g,
                       input logic v, input logic [1:0] id, input logic p);
        logic [N-1:0] eg;
        eg = '0;
        if (owner[m] >= 0) eg[owner[m]] = 1'b1;
        check({tag, ".gnt"}, 32'(g), 32'(eg));
        check({tag, ".valid"}, 32'(v), 32'(owner[m] >= 0));
        check({tag, ".id"}, 32'(id), (owner[m] < 0) ? 0 : owner[m]);
        check({tag, ".preempt"}, 32'(p), 32'(pre[m]));
        check({tag, ".onehot"}, 32'($onehot0(g)), 1);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("rr", 0, bus0.gnt, bus0.gnt_valid, bus0.gnt_id, bus0.preempt);
            cmp("fp", 1, bus1.gnt, bus1.gnt_valid, bus1.gnt_id, bus1.preempt);
        end
    end

    task automatic cyc(input logic [N-1:0] r);
        req = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] r;
        int owned;
        bit changed;

        reset = 1'b1;
        req   = '0;
        @(posedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        check("rst.gnt", 32'(bus0.gnt), 0);
        check("rst.valid", 32'(bus0.gnt_valid), 0);
        check("rst.id", 32'(bus0.gnt_id), 0);
        check("rst.preempt", 32'(bus0.preempt), 0);
        reset = 1'b0;

        repeat (5) begin
            cyc(4'b0000);
            check("idle.gnt", 32'(bus0.gnt), 0);
            check("idle.valid", 32'(bus0.gnt_valid), 0);
            check("idle.id", 32'(bus0.gnt_id), 0);
        end

        // Round-robin rotation with one-cycle drops
        cyc(4'b1111);
        check("rr.first", 32'(bus0.gnt), 32'h1);
        for (int k = 0; k < N; k++) begin
            cyc(4'b1111);
            check("rr.hold", 32'(bus0.gnt), 32'(1) << k);
            cyc(4'b1111);
            check("rr.hold", 32'(bus0.gnt), 32'(1) << k);
            r = 4'b1111;
            r[k] = 1'b0;
            cyc(r);
            check("rr.next", 32'(bus0.gnt), 32'(1) << ((k + 1) % N));
            check("rr.nogap", 32'(bus0.gnt_valid), 1);
        end

        // Fixed priority: index 0 beats 3
        cyc(4'b0000);
        cyc(4'b0000);
        check("fp.idle", 32'(bus1.gnt), 0);
        cyc(4'b1010);
        check("fp.a.gnt", 32'(bus1.gnt), 32'h2);
        check("fp.a.id", 32'(bus1.gnt_id), 1);
        cyc(4'b1001);
        check("fp.b.gnt", 32'(bus1.gnt), 32'h1);
        check("fp.b.id", 32'(bus1.gnt_id), 0);

        // One-cycle latency in and out
        cyc(4'b0000);
        cyc(4'b0000);
        cyc(4'b0100);
        check("lat.rr", 32'(bus0.gnt), 32'h4);
        check("lat.fp", 32'(bus1.gnt), 32'h4);
        repeat (4) begin
            cyc(4'b0100);
            check("lat.hold", 32'(bus0.gnt), 32'h4);
        end
        cyc(4'b0000);
        check("lat.rel.rr", 32'(bus0.gnt), 0);
        check("lat.rel.fp", 32'(bus1.gnt), 0);

        // Holder 0 with competitor 2 raised on its third cycle
        cyc(4'b0000);
        cyc(4'b0001);
        check("to.grant", 32'(bus0.gnt), 32'h1);
        owned = 1;
        repeat (2) begin
            cyc(4'b0001);
            owned++;
        end
        changed = 1'b0;
        for (int c = 0; c < 40 && !changed; c++) begin
            cyc(4'b0101);
            if (bus0.gnt == 4'b0001) owned++;
            else changed = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        check("to.owned", owned, MH);
        check("to.gnt", 32'(bus0.gnt), 32'h4);
        check("to.preempt", 32'(bus0.preempt), 1);
        cyc(4'b0101);
        check("to.pulse", 32'(bus0.preempt), 0);
        check("to.keep", 32'(bus0.gnt), 32'h4);
`else
        check("to.held", 32'(changed), 0);
        check("to.gnt", 32'(bus0.gnt), 32'h1);
        check("to.preempt", 32'(bus0.preempt), 0);
`endif

        // Sole requester is never preempted
        cyc(4'b0000);
        cyc(4'b0001);
        repeat (45) begin
            cyc(4'b0001);
            check("solo.gnt", 32'(bus0.gnt), 32'h1);
            check("solo.preempt", 32'(bus0.preempt), 0);
        end

        // Reset mid-grant, then pointer must restart at 0
        cyc(4'b0000);
        cyc(4'b1000);
        check("mid.gnt", 32'(bus0.gnt), 32'h8);
        reset = 1'b1;
        cyc(4'b1000);
        check("mid.rst.gnt", 32'(bus0.gnt), 0);
        check("mid.rst.valid", 32'(bus0.gnt_valid), 0);
        check("mid.rst.id", 32'(bus0.gnt_id), 0);
        reset = 1'b0;
        cyc(4'b0000);
        cyc(4'b1001);
        check("mid.ptr", 32'(bus0.gnt), 32'h1);

        cyc(4'b0000);
        cyc(4'b0010);
        check("mid2.gnt", 32'(bus0.gnt), 32'h2);
        reset = 1'b1;
        cyc(4'b0010);
        check("mid2.rst", 32'(bus0.gnt), 0);
        reset = 1'b0;
        cyc(4'b0000);
        cyc(4'b1001);
        check("mid2.ptr", 32'(bus0.gnt), 32'h1);

        // Random traffic with slowly changing requests
        r = '0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) r[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 99) == 0) r = N'($urandom);
            reset = ($urandom_range(0, 299) == 0);
            cyc(r);
        end
        reset = 1'b0;
        cyc(4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
